// File: rtl/mastermind_board_input.sv
// mastermind_board_input
//   Game-state stage feeding the VGA text renderer. Five raw push-buttons are
//   synchronized, optionally debounced, edge-detected and turned into edits of
//   a 4-row x 4-digit guess board.
//
// Optional feature macro: BOARD_DEBOUNCE_EN
//   defined   : per-button DEB_W-bit counter; the accepted level follows the
//               synchronized level only after it has differed for DEB_CYCLES
//               consecutive cycles (event latency 2 + DEB_CYCLES + 1).
//   undefined : no counters; the accepted level is the synchronized level
//               registered once (event latency 3). DEB_W/DEB_CYCLES unused.
//
// Ports
//   clk          system / pixel clock
//   rst          synchronous active-high reset
//   btn_up, btn_down, btn_left, btn_right, btn_enter
//                raw asynchronous buttons, active-high
//   nums         board; nums[r][3] is the leftmost digit of row r
//   curr_num     active row index 0..3
//   curr_col     cursor column, 0 = leftmost (nums[curr_num][3-curr_col])
//   board_full   high while the board is full
//   commit_pulse one-cycle strobe while a row is being committed
module mastermind_board_input #(
  parameter logic [3:0]       DIGIT_MAX  = 4'd9,
  parameter int               DEB_W      = 20,
  parameter logic [DEB_W-1:0] DEB_CYCLES = DEB_W'(800000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_enter,
  output logic [3:0][3:0]      nums [0:3],
  output logic [1:0]           curr_num,
  output logic [1:0]           curr_col,
  output logic                 board_full,
  output logic                 commit_pulse
);

  // Button vector bit positions, also the priority order (higher wins).
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_ENTER = 4;

  localparam logic [1:0] ST_EDIT   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  logic [4:0] btn_raw;
  logic [4:0] sync_p0;
  logic [4:0] sync_p1;
  logic [4:0] acc_p2;
  logic [4:0] acc_prev;
  logic [4:0] evt;
  logic [1:0] state;

  assign btn_raw = {btn_enter, btn_up, btn_down, btn_left, btn_right};

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] d);
    return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
  endfunction

  // ---- stage p0/p1: two-flop synchronizer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: accepted (debounced) level ----
`ifdef BOARD_DEBOUNCE_EN
  logic [DEB_W-1:0] deb_cnt [0:4];

  // The counter only runs while the synchronized level disagrees with the
  // accepted level and clears on acceptance, so it never passes DEB_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2 <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == acc_p2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= DEB_CYCLES) begin
          acc_p2[i]  <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic deb_unused;
  assign deb_unused = ^DEB_CYCLES;

  always_ff @(posedge clk) begin
    if (rst) acc_p2 <= '0;
    else     acc_p2 <= sync_p1;
  end
`endif

  // ---- rising-edge detect: one-cycle events ----
  always_ff @(posedge clk) begin
    if (rst) acc_prev <= '0;
    else     acc_prev <= acc_p2;
  end

  assign evt = acc_p2 & ~acc_prev;

  // ---- board FSM ----
  // Events are only consumed in EDIT and FULL; anything arriving during the
  // single COMMIT cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EDIT;
      curr_num     <= 2'd0;
      curr_col     <= 2'd0;
      board_full   <= 1'b0;
      commit_pulse <= 1'b0;
      for (int r = 0; r < 4; r++) nums[r] <= '0;
    end else begin
      commit_pulse <= 1'b0;
      case (state)
        ST_EDIT: begin
          if (evt[B_ENTER]) begin
            state        <= ST_COMMIT;
            commit_pulse <= 1'b1;
          end else if (evt[B_UP]) begin
            nums[curr_num][2'd3 - curr_col] <= digit_inc(nums[curr_num][2'd3 - curr_col]);
          end else if (evt[B_DOWN]) begin
            nums[curr_num][2'd3 - curr_col] <= digit_dec(nums[curr_num][2'd3 - curr_col]);
          end else if (evt[B_LEFT]) begin
            curr_col <= curr_col - 2'd1;
          end else if (evt[B_RIGHT]) begin
            curr_col <= curr_col + 2'd1;
          end
        end
        ST_COMMIT: begin
          if (curr_num == 2'd3) begin
            state      <= ST_FULL;
            board_full <= 1'b1;
          end else begin
            curr_num <= curr_num + 2'd1;
            curr_col <= 2'd0;
            state    <= ST_EDIT;
          end
        end
        ST_FULL: begin
          if (evt[B_ENTER]) begin
            for (int r = 0; r < 4; r++) nums[r] <= '0;
            curr_num   <= 2'd0;
            curr_col   <= 2'd0;
            board_full <= 1'b0;
            state      <= ST_EDIT;
          end
        end
        default: state <= ST_EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_board_input.sv
module tb_mastermind_board_input;

`ifdef BOARD_DEBOUNCE_EN
  localparam int LAT = 2 + 4 + 1;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = LAT + 4;
  localparam int GAP  = LAT + 4;
  localparam int DMAX = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_enter = 1'b0;
  logic [3:0][3:0] nums [0:3];
  logic [1:0] curr_num, curr_col;
  logic board_full, commit_pulse;

  mastermind_board_input #(
    .DIGIT_MAX (4'd9),
    .DEB_W     (20),
    .DEB_CYCLES(20'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_enter   (btn_enter),
    .nums        (nums),
    .curr_num    (curr_num),
    .curr_col    (curr_col),
    .board_full  (board_full),
    .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] board;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        full;
    logic        pulse;
  } snap_t;

  typedef struct packed {
    snap_t       s;
    logic [31:0] at;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: board as m[row][column], column 0 = leftmost on screen.
  int m_dig [4][4];
  int m_row, m_col;
  bit m_full;

  function automatic snap_t dut_snap();
    snap_t s;
    for (int r = 0; r < 4; r++) s.board[r*16 +: 16] = nums[r];
    s.row = curr_num;
    s.col = curr_col;
    s.full = board_full;
    s.pulse = commit_pulse;
    return s;
  endfunction

  function automatic snap_t model_snap(input bit pulse);
    snap_t s;
    s.board = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s.board[r*16 + (3-c)*4 +: 4] = 4'(m_dig[r][c]);
    s.row = 2'(m_row);
    s.col = 2'(m_col);
    s.full = m_full;
    s.pulse = pulse;
    return s;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m_dig[r][c] = 0;
    m_row = 0;
    m_col = 0;
    m_full = 0;
  endtask

  task automatic push(input bit pulse, input int at);
    exp_t e;
    e.s = model_snap(pulse);
    e.at = 32'(at);
    q.push_back(e);
  endtask

  // mask bits: 4 enter, 3 up, 2 down, 1 left, 0 right. c = cycle of the rise.
  task automatic model_apply(input logic [4:0] mask, input int c);
    if (!m_full) begin
      if (mask[4]) begin
        push(1'b1, c + LAT + 1);
        if (m_row == 3) m_full = 1;
        else begin m_row++; m_col = 0; end
        push(1'b0, c + LAT + 2);
      end else if (mask[3]) begin
        m_dig[m_row][m_col] = (m_dig[m_row][m_col] == DMAX) ? 0 : m_dig[m_row][m_col] + 1;
        push(1'b0, c + LAT + 1);
      end else if (mask[2]) begin
        m_dig[m_row][m_col] = (m_dig[m_row][m_col] == 0) ? DMAX : m_dig[m_row][m_col] - 1;
        push(1'b0, c + LAT + 1);
      end else if (mask[1]) begin
        m_col = (m_col + 3) % 4;
        push(1'b0, c + LAT + 1);
      end else if (mask[0]) begin
        m_col = (m_col + 1) % 4;
        push(1'b0, c + LAT + 1);
      end
    end else if (mask[4]) begin
      model_reset();
      push(1'b0, c + LAT + 1);
    end
  endtask

  task automatic drive(input logic [4:0] mask);
    btn_enter = mask[4];
    btn_up    = mask[3];
    btn_down  = mask[2];
    btn_left  = mask[1];
    btn_right = mask[0];
  endtask

  // Called on a negedge; returns on a negedge.
  task automatic press(input logic [4:0] mask);
    model_apply(mask, cyc);
    drive(mask);
    repeat (HOLD) @(negedge clk);
    drive(5'b0);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every visible output change must match the next queued expectation.
  initial begin
    snap_t prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = dut_snap();
      if (rst) begin
        prev = cur;
      end else if (cur != prev) begin
        prev = cur;
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_update: got board=%h row=%0d col=%0d full=%0b pulse=%0b at cycle %0d, expected no change",
                   cur.board, cur.row, cur.col, cur.full, cur.pulse, cyc);
        end else begin
          e = q.pop_front();
          if (e.s != cur || e.at != 32'(cyc)) begin
            mismatched++;
            $display("FAIL update: got board=%h row=%0d col=%0d full=%0b pulse=%0b cyc=%0d, expected board=%h row=%0d col=%0d full=%0b pulse=%0b cyc=%0d",
                     cur.board, cur.row, cur.col, cur.full, cur.pulse, cyc,
                     e.s.board, e.s.row, e.s.col, e.s.full, e.s.pulse, e.at);
          end
        end
      end
    end
  end

  initial begin
    logic [4:0] mask;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", 64'(dut_snap()), 64'(model_snap(1'b0)));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 3 ups on column 0
    repeat (3) press(5'b01000);
    check("three_ups_digit", 64'(nums[0][3]), 64'd3);
    check("three_ups_col", 64'(curr_col), 64'd0);
    // left wraps to 3, down on zero -> 9, up at 9 -> 0
    press(5'b00010);
    check("left_wrap_col", 64'(curr_col), 64'd3);
    press(5'b00100);
    check("down_wrap_digit", 64'(nums[0][0]), 64'd9);
    press(5'b01000);
    check("up_wrap_digit", 64'(nums[0][0]), 64'd0);
    // two rights -> column 1, up -> nums[0][2] = 1
    repeat (2) press(5'b00001);
    press(5'b01000);
    check("col1_digit", 64'(nums[0][2]), 64'd1);
    // four commits fill the board, then up ignored, enter clears
    repeat (4) press(5'b10000);
    check("full_flag", 64'(board_full), 64'd1);
    press(5'b01000);
    press(5'b10000);
    check("cleared_full", 64'(board_full), 64'd0);
    // enter together with up: only the commit
    press(5'b01000);
    press(5'b11000);
    check("combo_row0_digit", 64'(nums[0][3]), 64'd1);
    check("combo_row", 64'(curr_num), 64'd1);

`ifdef BOARD_DEBOUNCE_EN
    // glitch shorter than the debounce window: no event
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_ignored", 64'(dut_snap()), 64'(model_snap(1'b0)));
`endif

    // randomized presses, mostly single buttons, some simultaneous
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 7) mask = 5'(1 << $urandom_range(0, 4));
      else mask = 5'($urandom_range(1, 31));
      press(mask);
    end

    // button held through reset: one event after the full latency
    check("queue_drained_before_reset", 64'(q.size()), 64'd0);
    rst = 1'b1;
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_again", 64'(dut_snap()), 64'(0));
    model_reset();
    model_apply(5'b01000, cyc);
    rst = 1'b0;
    repeat (HOLD) @(negedge clk);
    btn_up = 1'b0;
    repeat (GAP + 10) @(negedge clk);

    check("queue_drained", 64'(q.size()), 64'd0);
    check("final_state", 64'(dut_snap()), 64'(model_snap(1'b0)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
